// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the byte FIFO and serialises each one as an
// asynchronous UART frame on txd (start, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits). Every output is registered.
module fifo_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned      DIV_W       = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_RELOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       LAST_STOP   = 3'(STOP_BITS - 1);
  localparam logic             PAR_EN      = (PARITY_EN != 0);
  localparam logic             PAR_ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity_bit;

  // Frame sequencer; outputs are set on the edge entering the cycle they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          if (enable && !fifo_empty) begin
            state      <= S_REQ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          // fifo_data is valid this cycle, one cycle after the pop
          shreg      <= fifo_data;
          parity_bit <= (^fifo_data) ^ PAR_ODD_BIT;
          txd        <= 1'b0;
          div_cnt    <= DIV_RELOAD;
          state      <= S_START;
        end
        S_START: begin
          if (div_cnt == '0) begin
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= '0;
            div_cnt <= DIV_RELOAD;
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_RELOAD;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PAR_EN) begin
                txd   <= parity_bit;
                state <= S_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (div_cnt == '0) begin
            txd     <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= DIV_RELOAD;
            state   <= S_STOP;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_STOP: begin
          txd <= 1'b1;
          // Pulse lands on the very last cycle of the final stop bit
          if ((div_cnt == DIV_W'(1)) && (bit_cnt == LAST_STOP)) begin
            frame_done <= 1'b1;
          end
          if (div_cnt == '0) begin
            div_cnt <= DIV_RELOAD;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (enable && !fifo_empty) begin
                state      <= S_REQ;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances at CLK_DIV=4 covering
// 8N1, 8E2 and 8O2 framing, with a small byte FIFO model feeding the 8N1 one.
module tb_fifo_uart_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;

  logic [7:0] mem0 [0:15];
  logic [3:0] wr0 = '0;
  logic [3:0] rd0 = '0;
  logic [7:0] fifo_data0 = '0;
  logic       fifo_empty0;
  logic       rd_en0, txd0, busy0, done0;

  logic [7:0] p_data;
  int         p_avail1 = 0, p_pops1 = 0;
  int         p_avail2 = 0, p_pops2 = 0;
  logic       p_empty1, p_empty2;
  logic       rd_en1, txd1, busy1, done1;
  logic       rd_en2, txd2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n, n1, n2;

  always #5 clk = ~clk;

  assign fifo_empty0 = (rd0 == wr0);
  assign p_empty1    = (p_pops1 >= p_avail1);
  assign p_empty2    = (p_pops2 >= p_avail2);

  // FIFO model: read data appears the cycle after a pop
  always @(posedge clk) begin
    if (rd_en0 && !fifo_empty0) begin
      fifo_data0 <= mem0[rd0];
      rd0        <= rd0 + 4'd1;
    end
    if (rd_en1) p_pops1 <= p_pops1 + 1;
    if (rd_en2) p_pops2 <= p_pops2 + 1;
  end

  fifo_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty0),
    .fifo_data(fifo_data0), .fifo_rd_en(rd_en0), .txd(txd0), .busy(busy0),
    .frame_done(done0));

  fifo_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(p_empty1),
    .fifo_data(p_data), .fifo_rd_en(rd_en1), .txd(txd1), .busy(busy1),
    .frame_done(done1));

  fifo_uart_tx #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(p_empty2),
    .fifo_data(p_data), .fifo_rd_en(rd_en2), .txd(txd2), .busy(busy2),
    .frame_done(done2));

  wire [2:0] txd_v  = {txd2, txd1, txd0};
  wire [2:0] rd_v   = {rd_en2, rd_en1, rd_en0};
  wire [2:0] busy_v = {busy2, busy1, busy0};
  wire [2:0] done_v = {done2, done1, done0};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the pop, then check every txd cycle of the frame and frame_done.
  // par is the hand-computed parity bit (ignored for the 8N1 instance).
  // drop_sym / abort_sym: symbol index at which enable is dropped / reset pulsed.
  task automatic run_frame(input int sel, input logic [7:0] data, input logic par,
                           input int drop_sym, input int abort_sym, output int n_pop);
    logic [11:0] sym;
    int          nsym;
    int          guard;
    sym    = '1;
    sym[0] = 1'b0;
    sym[8:1] = data;
    if (sel == 0) begin
      nsym = 10;
    end else begin
      nsym   = 12;
      sym[9] = par;
    end
    guard = 0;
    while (rd_v[sel] !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("pop_seen", 32'(rd_v[sel]), 32'd1);
    n_pop = cyc;
    tick();
    chk("load_rd_low", 32'(rd_v[sel]), 32'd0);
    chk("load_txd", 32'(txd_v[sel]), 32'd1);
    chk("load_busy", 32'(busy_v[sel]), 32'd1);
    for (int s = 0; s < nsym; s++) begin
      for (int c = 0; c < DIV; c++) begin
        tick();
        chk($sformatf("txd_s%0d_c%0d", s, c), 32'(txd_v[sel]), 32'(sym[s]));
        chk($sformatf("done_s%0d_c%0d", s, c), 32'(done_v[sel]),
            32'((s == nsym - 1) && (c == DIV - 1)));
        if (s == drop_sym && c == 1) enable = 1'b0;
        if (s == abort_sym && c == 1) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          chk("abort_txd", 32'(txd_v[sel]), 32'd1);
          chk("abort_busy", 32'(busy_v[sel]), 32'd0);
          chk("abort_done", 32'(done_v[sel]), 32'd0);
          chk("abort_rd", 32'(rd_v[sel]), 32'd0);
          return;
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    p_data = 8'h07;
    mem0[0] = 8'hA5;
    wr0     = 4'd1;

    // Reset held with data available
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_txd", 32'(txd0), 32'd1);
      chk("rst_rd", 32'(rd_en0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
    end
    rst_n = 1'b1;

    // Single byte 0xA5, 8N1
    run_frame(0, 8'hA5, 1'b0, -1, -1, n);
    tick();
    chk("a5_busy_fall", 32'(busy0), 32'd0);
    chk("a5_idle_txd", 32'(txd0), 32'd1);

    // Back-to-back 0x55 then 0x0F
    mem0[1] = 8'h55;
    mem0[2] = 8'h0F;
    wr0     = 4'd3;
    run_frame(0, 8'h55, 1'b0, -1, -1, n1);
    tick();
    chk("b2b_pop", 32'(rd_en0), 32'd1);
    chk("b2b_req_txd", 32'(txd0), 32'd1);
    run_frame(0, 8'h0F, 1'b0, -1, -1, n2);
    chk("b2b_gap", 32'(n2 - n1), 32'd42);
    tick();
    chk("b2b_busy_fall", 32'(busy0), 32'd0);

    // 0x07 with even parity (bit 1) and two stop bits
    p_avail1 = 1;
    run_frame(1, 8'h07, 1'b1, -1, -1, n);
    tick();
    chk("even_busy_fall", 32'(busy1), 32'd0);
    chk("even_no_repop", 32'(rd_en1), 32'd0);

    // 0x07 with odd parity (bit 0)
    p_avail2 = 1;
    run_frame(2, 8'h07, 1'b0, -1, -1, n);
    tick();
    chk("odd_busy_fall", 32'(busy2), 32'd0);

    // enable dropped during data bit 3 with more data queued
    mem0[3] = 8'h3C;
    mem0[4] = 8'hC3;
    wr0     = 4'd5;
    run_frame(0, 8'h3C, 1'b0, 4, -1, n);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_rd", 32'(rd_en0), 32'd0);
      chk("hold_busy", 32'(busy0), 32'd0);
    end
    enable = 1'b1;
    tick();
    chk("resume_pop", 32'(rd_en0), 32'd1);
    run_frame(0, 8'hC3, 1'b0, -1, -1, n);
    tick();
    chk("resume_busy_fall", 32'(busy0), 32'd0);

    // Reset pulse during data bit 5; next byte must follow
    mem0[5] = 8'h96;
    mem0[6] = 8'h42;
    wr0     = 4'd7;
    run_frame(0, 8'h96, 1'b0, -1, 6, n);
    tick();
    chk("post_rst_pop", 32'(rd_en0), 32'd1);
    run_frame(0, 8'h42, 1'b0, -1, -1, n);
    tick();
    chk("final_busy_fall", 32'(busy0), 32'd0);
    chk("final_txd", 32'(txd0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
